// File: rtl/mem_pkg.sv
// mem_pkg: shared types and line geometry for the burst memory responder
package mem_pkg;
  localparam int BURST_LEN = 8;
  localparam int LINE_BYTES = BURST_LEN * 2;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
endpackage

// File: rtl/mem_burst_responder_if.sv
// mem_burst_responder_if: cache-to-memory request/response bus
interface mem_burst_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              busy;
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, busy
  );
endinterface

// File: rtl/mem_array_1rw.sv
// mem_array_1rw: single-port word array, synchronous write, combinational read
module mem_array_1rw #(
  parameter int DEPTH = 32768,
  parameter int DATA_W = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: fixed-latency line-fill / write-through memory model
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LATENCY = 4,
  parameter int BURST_LEN = mem_pkg::BURST_LEN,
  parameter int MEM_WORDS = 32768
) (
  input logic clk,
  input logic rst_n,
  mem_burst_responder_if.slave bus
);
  localparam int OFF_W = $clog2(BURST_LEN * 2);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam int AW = $clog2(MEM_WORDS);
  state_t state, nextState;
  logic [LAT_W-1:0] lat, nextLat;
  logic [CNT_W-1:0] cnt, nextCnt, rdCnt;
  logic [ADDR_W-1:0] lineBase, nextBase, rdAddr;
  logic [DATA_W-1:0] rdata;
  logic accept, loadWord;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign accept = bus.req_valid && bus.req_ready;
  // line_base is aligned, so OR-ing the word offset is the same as adding it
  assign rdAddr = lineBase | (ADDR_W'(rdCnt) << 1);
  mem_array_1rw #(.DEPTH(MEM_WORDS), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .we(accept && bus.req_write),
    .addr(state == IDLE ? bus.req_addr[AW:1] : rdAddr[AW:1]),
    .wdata(bus.req_wdata),
    .rdata(rdata)
  );
  // rsp outputs are loaded one edge ahead, so the word index is cnt+1 while bursting
  always_comb begin
    nextState = state;
    nextLat = lat;
    nextCnt = cnt;
    nextBase = lineBase;
    loadWord = 1'b0;
    rdCnt = '0;
    case (state)
      IDLE: if (accept && !bus.req_write) begin
        nextState = WAIT;
        nextLat = LAT_W'(LATENCY - 1);
        nextCnt = '0;
        nextBase = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      end
      WAIT: if (lat == '0) begin
        nextState = BURST;
        loadWord = 1'b1;
      end else nextLat = lat - 1'b1;
      BURST: if (&cnt) begin
        nextState = IDLE;
        nextCnt = '0;
      end else begin
        nextCnt = cnt + 1'b1;
        rdCnt = cnt + 1'b1;
        loadWord = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lat <= '0;
      cnt <= '0;
      lineBase <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_addr <= '0;
    end else begin
      state <= nextState;
      lat <= nextLat;
      cnt <= nextCnt;
      lineBase <= nextBase;
      bus.rsp_valid <= loadWord;
      if (loadWord) begin
        bus.rsp_data <= rdata;
        bus.rsp_addr <= rdAddr;
      end
    end
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: directed bench with a scoreboard of expected burst words
module tb_mem_burst_responder;
  localparam int LAT = 4;
  localparam int BL = 8;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int nTests = 0;
  int nFail = 0;
  exp_t sb[$];
  logic [15:0] model [int];
  always #5 clk = ~clk;
  mem_burst_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_burst_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .BURST_LEN(BL), .MEM_WORDS(32768)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask
  // Reference: track accepted writes, and on each read accept queue the whole line with its due cycle
  always @(posedge clk) begin
    logic [15:0] b;
    cyc++;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      if (bus.req_write) model[int'(bus.req_addr[15:1])] = bus.req_wdata;
      else begin
        b = {bus.req_addr[15:4], 4'h0};
        for (int k = 0; k < BL; k++)
          sb.push_back('{b + 16'(2 * k), model[int'(b[15:1]) + k], cyc + LAT + k});
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) check("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_addr", {16'd0, bus.rsp_addr}, {16'd0, e.addr});
        check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr = a;
    bus.req_wdata = d;
    #1 check("wr_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask
  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output int acc);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr = a;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rd_accept", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", sb.size(), 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask
  initial begin
    int c, c2;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    check("rst_rsp_addr", {16'd0, bus.rsp_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // preload mem[i] = i over the lines the reads below touch
    for (int i = 0; i < 136; i++) wr(16'(2 * i), 16'(i));
    for (int i = 0; i < 8; i++) wr(16'hFFF0 + 16'(2 * i), 16'h7FF8 + 16'(i));
    idle();
    rd(16'h0013, c);
    check("wait_busy", {31'd0, bus.busy}, 32'd1);
    check("wait_ready", {31'd0, bus.req_ready}, 32'd0);
    drain();
    wr(16'h0024, 16'hBEEF);
    idle();
    rd(16'h0020, c);
    drain();
    wr(16'h0100, 16'd1);
    wr(16'h0102, 16'd2);
    wr(16'h0104, 16'd3);
    idle();
    rd(16'h0100, c);
    drain();
    rd(16'h0040, c);
    rd(16'h0060, c2);
    check("held_accept_cycle", c2, c + LAT + BL + 1);
    drain();
    rd(16'h0020, c);
    while (cyc < c + LAT + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rd(16'h0020, c);
    drain();
    rd(16'hFFF0, c);
    drain();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
